// File: rtl/discr_in_filter.sv
// Discrete input conditioning: 2-flop sync, per-channel integrating debounce, Avalon-MM config.
// Optional rejected-transient counter on Reg3 when DISCR_IN_FILTER_GLITCH_EN is defined.
module discr_in_filter #(
    parameter int COUNT   = 32,
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             ams_waitrequest,
    input  logic             ams_write,
    input  logic             ams_read,
    input  logic [1:0]       ams_address,
    input  logic [31:0]      ams_writedata,
    output logic             ams_readdatavalid,
    output logic [31:0]      ams_readdata,
    input  logic [COUNT-1:0] raw_in,
    output logic [COUNT-1:0] flt_out,
    output logic             flt_change
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rd_mux;
    logic               accept;
    logic               wr_ctrl;
    logic               wr_len;

    logic               flt_en;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   n_eff;
    logic               tick;

    logic [COUNT-1:0]   sync1;
    logic [COUNT-1:0]   sync2;
    logic [COUNT-1:0]   flt_d;
    logic [COUNT-1:0]   flt_nxt;
    logic [CNT_W-1:0]   cnt     [COUNT];
    logic [CNT_W-1:0]   cnt_nxt [COUNT];

`ifdef DISCR_IN_FILTER_GLITCH_EN
    logic [COUNT-1:0]   dir;
    logic [COUNT-1:0]   dir_nxt;
    logic               glitch_hit;
    logic               wr_glitch;
    logic [15:0]        glitch_cnt;
`endif

    assign accept          = (state == ST_IDLE) && (ams_write || ams_read);
    assign ams_waitrequest = !accept;
    assign wr_ctrl         = (state == ST_WRITE) && (addr_q == 2'd0);
    assign wr_len          = (state == ST_WRITE) && (addr_q == 2'd1);
    assign n_eff           = (len == '0) ? CNT_W'(1) : len;
    assign tick            = (presc_cnt == presc);

    always_comb begin
        rd_mux = '0;
        case (ams_address)
            2'd0: begin
                rd_mux[0]           = flt_en;
                rd_mux[PRESC_W+7:8] = presc;
            end
            2'd1:    rd_mux[CNT_W-1:0] = len;
            2'd2:    rd_mux[COUNT-1:0] = flt_out;
            default: begin
`ifdef DISCR_IN_FILTER_GLITCH_EN
                rd_mux[15:0] = glitch_cnt;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            ams_readdatavalid <= 1'b0;
            ams_readdata      <= '0;
        end else begin
            ams_readdatavalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ams_write) begin
                        state   <= ST_WRITE;
                        addr_q  <= ams_address;
                        wdata_q <= ams_writedata;
                    end else if (ams_read) begin
                        state             <= ST_READ;
                        ams_readdata      <= rd_mux;
                        ams_readdatavalid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_en    <= 1'b1;
            presc     <= PRESC_W'(99);
            len       <= CNT_W'(4);
            presc_cnt <= '0;
        end else begin
            if (wr_ctrl) begin
                flt_en <= wdata_q[0];
                presc  <= wdata_q[PRESC_W+7:8];
            end
            if (wr_len) len <= wdata_q[CNT_W-1:0];
            if (wr_ctrl || tick) presc_cnt <= '0;
            else                 presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Bypass takes sync1 so the flt_out register itself is the second sync stage (2-clk path);
    // counters are preloaded from the same value so re-enabling does not move the output.
    always_comb begin
        cnt_nxt = cnt;
        flt_nxt = flt_out;
`ifdef DISCR_IN_FILTER_GLITCH_EN
        dir_nxt    = dir;
        glitch_hit = 1'b0;
`endif
        for (int unsigned i = 0; i < COUNT; i++) begin
            if (!flt_en) begin
                flt_nxt[i] = sync1[i];
                cnt_nxt[i] = sync1[i] ? n_eff : '0;
            end else if (tick) begin
                if (cnt[i] > n_eff)                       cnt_nxt[i] = n_eff;
                else if (sync2[i] && (cnt[i] < n_eff))    cnt_nxt[i] = cnt[i] + 1'b1;
                else if (!sync2[i] && (cnt[i] != '0))     cnt_nxt[i] = cnt[i] - 1'b1;
                if (cnt_nxt[i] == n_eff)                  flt_nxt[i] = 1'b1;
                else if (cnt_nxt[i] == '0)                flt_nxt[i] = 1'b0;
`ifdef DISCR_IN_FILTER_GLITCH_EN
                if (cnt_nxt[i] != cnt[i]) begin
                    dir_nxt[i] = (cnt_nxt[i] > cnt[i]);
                    if ((dir_nxt[i] == flt_out[i]) && (dir[i] != flt_out[i]) &&
                        (flt_nxt[i] == flt_out[i]))
                        glitch_hit = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            flt_out    <= '0;
            flt_d      <= '0;
            flt_change <= 1'b0;
            cnt        <= '{default: '0};
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            cnt        <= cnt_nxt;
            flt_out    <= flt_nxt;
            flt_d      <= flt_out;
            flt_change <= |(flt_out ^ flt_d);
        end
    end

`ifdef DISCR_IN_FILTER_GLITCH_EN
    assign wr_glitch = (state == ST_WRITE) && (addr_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir        <= '0;
            glitch_cnt <= '0;
        end else begin
            dir <= dir_nxt;
            if (wr_glitch)                                   glitch_cnt <= '0;
            else if (glitch_hit && (glitch_cnt != 16'hFFFF)) glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule
